// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// uart_rx_ctrl: UART receive controller sitting downstream of an oversampling
// edge counter. It enables the counter for the duration of a frame, takes a
// three-point majority vote around mid-bit, deserialises DATA_W bits LSB
// first, checks the optional parity bit and the stop bit, and reports the
// outcome with one-cycle strobes one cycle after the stop bit ends.
//
// Build option UART_RX_SYNC_EN: when defined, rx_in first passes through a
// two-flop synchroniser (reset to idle-high), delaying start detection and
// strobes by two cycles. When undefined, rx_in must already be synchronous.
module uart_rx_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_in,
  input  logic [5:0]        prescale,
  input  logic              parity_en,
  input  logic              parity_type,
  input  logic [4:0]        edge_count,
  input  logic              edge_count_done,
  output logic              edge_cnt_en,
  output logic [DATA_W-1:0] p_data,
  output logic              data_valid,
  output logic              parity_error,
  output logic              stop_error,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state;
  logic               line;
  logic [2:0]         samp;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  shift;
  logic               par_err;
  logic               prescale_ok;
  logic               bit_val;
  logic [4:0]         mid;
  logic [4:0]         mid_lo;
  logic [4:0]         mid_hi;

  // Two of three samples decide the bit value.
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

`ifdef UART_RX_SYNC_EN
  logic rx_p0;
  logic rx_p1;

  // Two-flop synchroniser, reset to the idle-high line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_in;
      rx_p1 <= rx_p0;
    end
  end

  assign line = rx_p1;
`else
  assign line = rx_in;
`endif

  assign prescale_ok = (prescale == 6'd8) || (prescale == 6'd16) || (prescale == 6'd32);
  assign mid         = prescale[5:1];
  assign mid_lo      = mid - 5'd1;
  assign mid_hi      = mid + 5'd1;
  assign bit_val     = majority3(samp);
  assign busy        = (state != IDLE);

  // The counter starts in the same cycle the start edge is seen so that
  // this cycle is count 0 of the start bit.
  assign edge_cnt_en = (state != IDLE) || (prescale_ok && !line);

  // Mid-bit sampling window; cleared at the start of every bit period.
  always_ff @(posedge clk) begin
    if (edge_count == 5'd0) begin
      samp <= 3'b000;
    end else begin
      if (edge_count == mid_lo) samp[0] <= line;
      if (edge_count == mid)    samp[1] <= line;
      if (edge_count == mid_hi) samp[2] <= line;
    end
  end

  // Deserialiser: each data bit lands at its own position, LSB first.
  always_ff @(posedge clk) begin
    if ((state == DATA) && edge_count_done) shift[bit_cnt] <= bit_val;
  end

  // Frame FSM with registered strobes and received-byte register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      par_err      <= 1'b0;
      p_data       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      case (state)
        IDLE: begin
          if (prescale_ok && !line) begin
            state   <= START;
            bit_cnt <= '0;
            par_err <= 1'b0;
          end
        end
        START: begin
          if (edge_count_done) begin
            if (bit_val) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (edge_count_done) begin
            if (bit_cnt == LAST_BIT) begin
              state <= parity_en ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (edge_count_done) begin
            par_err <= (bit_val != ((^shift) ^ parity_type));
            state   <= STOP;
          end
        end
        STOP: begin
          if (edge_count_done) begin
            state        <= IDLE;
            stop_error   <= !bit_val;
            parity_error <= par_err;
            if (bit_val && !par_err) begin
              data_valid <= 1'b1;
              p_data     <= shift;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_ctrl. Includes a model of the oversampling
// edge counter, a frame-level reference model that fills per-cycle expected
// output tables, and a per-cycle compare process.
module tb_uart_rx_ctrl;

  localparam int MAXC = 24000;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd16;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic [4:0] edge_count;
  logic       edge_count_done;
  logic       edge_cnt_en;
  logic [7:0] p_data;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;
  logic       busy;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  bit         exp_en   [MAXC];
  bit         exp_busy [MAXC];
  bit         exp_dv   [MAXC];
  bit         exp_pe   [MAXC];
  bit         exp_se   [MAXC];
  logic [7:0] exp_byte [MAXC];
  logic [7:0] dv_log [$];

  bit line_buf [0:351];
  int line_len;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oversampling edge counter feeding the DUT.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_count <= 5'd0;
    else if (!edge_cnt_en || (int'(edge_count) == int'(prescale) - 1)) edge_count <= 5'd0;
    else edge_count <= edge_count + 5'd1;
  end
  assign edge_count_done = (int'(edge_count) == int'(prescale) - 1);

  uart_rx_ctrl #(.DATA_W(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx_in           (rx_in),
    .prescale        (prescale),
    .parity_en       (parity_en),
    .parity_type     (parity_type),
    .edge_count      (edge_count),
    .edge_count_done (edge_count_done),
    .edge_cnt_en     (edge_cnt_en),
    .p_data          (p_data),
    .data_valid      (data_valid),
    .parity_error    (parity_error),
    .stop_error      (stop_error),
    .busy            (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit maj3(input bit a, input bit b, input bit c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  // Frame-level reference: decode the driven waveform and record what the
  // DUT must show on each cycle.
  task automatic model_add(input int c0);
    int P, mid, s, nb, L, ones, e;
    bit b [0:10];
    logic [7:0] d;
    bit perr;
    P   = int'(prescale);
    mid = P / 2;
    s   = c0 + LAT;
    nb  = line_len / P;
    for (int j = 0; j < nb; j++)
      b[j] = maj3(line_buf[j*P+mid-1], line_buf[j*P+mid], line_buf[j*P+mid+1]);
    if (b[0]) begin
      for (int k = 0; k < P; k++) if (s + k < MAXC) exp_en[s+k] = 1'b1;
      for (int k = 1; k < P; k++) if (s + k < MAXC) exp_busy[s+k] = 1'b1;
      return;
    end
    L = 10 + int'(parity_en);
    for (int k = 0; k < L*P; k++) if (s + k < MAXC) exp_en[s+k] = 1'b1;
    for (int k = 1; k < L*P; k++) if (s + k < MAXC) exp_busy[s+k] = 1'b1;
    for (int i = 0; i < 8; i++) d[i] = b[1+i];
    ones = $countones(d) + (parity_en ? int'(b[9]) : 0);
    perr = parity_en && ((ones % 2) != int'(parity_type));
    e = s + L*P;
    if (e < MAXC) begin
      if (!b[L-1]) exp_se[e] = 1'b1;
      if (perr) exp_pe[e] = 1'b1;
      if (b[L-1] && !perr) begin
        exp_dv[e]   = 1'b1;
        exp_byte[e] = d;
      end
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      exp_en[i] = 0; exp_busy[i] = 0; exp_dv[i] = 0; exp_pe[i] = 0; exp_se[i] = 0;
    end
  endtask

  // Build a frame waveform; g1/g2 are cycle offsets to invert (-1 = none).
  task automatic build_frame(input logic [7:0] d, input bit par_ok, input bit stp,
                             input int g1, input int g2);
    int P, nb;
    bit bits [0:10];
    bit par;
    P  = int'(prescale);
    nb = 10 + int'(parity_en);
    par = (($countones(d) + int'(parity_type)) % 2) == 1;
    if (!par_ok) par = !par;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (parity_en) bits[9] = par;
    bits[nb-1] = stp;
    line_len = nb * P;
    for (int t = 0; t < line_len; t++) line_buf[t] = bits[t/P];
    if (g1 >= 0 && g1 < line_len) line_buf[g1] = !line_buf[g1];
    if (g2 >= 0 && g2 < line_len) line_buf[g2] = !line_buf[g2];
  endtask

  task automatic drive_line();
    model_add(cyc);
    for (int t = 0; t < line_len; t++) begin
      rx_in = line_buf[t];
      step();
    end
    rx_in = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input bit par_ok, input bit stp,
                      input int g1, input int g2);
    build_frame(d, par_ok, stp, g1, g2);
    drive_line();
  endtask

  // Per-cycle comparison against the model tables.
  initial begin
    logic [12:0] a, e;
    logic [7:0]  model_pd;
    model_pd = 8'h00;
    forever begin
      @(negedge clk);
      if (cyc < MAXC) begin
        if (!reset_n) model_pd = 8'h00;
        else if (exp_dv[cyc]) model_pd = exp_byte[cyc];
        if (data_valid) dv_log.push_back(p_data);
        a = {edge_cnt_en, busy, data_valid, parity_error, stop_error, p_data};
        e = {exp_en[cyc], exp_busy[cyc], exp_dv[cyc], exp_pe[cyc], exp_se[cyc], model_pd};
        check("cycle{en,busy,dv,pe,se,pdata}", 32'(a), 32'(e));
      end
    end
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: run exceeded %0d cycles", MAXC);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, P, nb, gsel, g1, g2, gap, j;
    logic [7:0] d;
    bit par_ok, stp;

    reset_n = 1'b0;
    rx_in   = 1'b1;
    repeat (3) step();
    check("reset_outputs", 32'({edge_cnt_en, busy, data_valid, parity_error, stop_error, p_data}), 32'd0);
    reset_n = 1'b1;
    repeat (3) step();

    // Test 1: 0xA5, prescale 16, no parity.
    prescale = 6'd16; parity_en = 1'b0;
    step();
    c0 = cyc;
    send(8'hA5, 1'b1, 1'b1, -1, -1);
    check("t1_model_strobe_cycle", 32'(exp_dv[c0 + 160 + LAT]), 32'd1);
    repeat (LAT) step();
    check("t1_dv", 32'(data_valid), 32'd1);
    check("t1_pdata", 32'(p_data), 32'hA5);
    check("t1_errs", 32'({parity_error, stop_error}), 32'd0);
    step();
    check("t1_dv_one_cycle", 32'(data_valid), 32'd0);
    repeat (4) step();

    // Test 2: prescale 8, even parity, 0x3C good then bad parity.
    prescale = 6'd8; parity_en = 1'b1; parity_type = 1'b0;
    step();
    send(8'h3C, 1'b1, 1'b1, -1, -1);
    repeat (LAT) step();
    check("t2_good_dv", 32'(data_valid), 32'd1);
    check("t2_good_pdata", 32'(p_data), 32'h3C);
    repeat (3) step();
    send(8'h3C, 1'b0, 1'b1, -1, -1);
    repeat (LAT) step();
    check("t2_bad_pe", 32'(parity_error), 32'd1);
    check("t2_bad_dv", 32'(data_valid), 32'd0);
    check("t2_bad_pdata_held", 32'(p_data), 32'h3C);
    repeat (4) step();

    // Test 3: prescale 32, 0x81, stop bit 0.
    prescale = 6'd32; parity_en = 1'b0;
    step();
    send(8'h81, 1'b1, 1'b0, -1, -1);
    repeat (LAT) step();
    check("t3_se", 32'(stop_error), 32'd1);
    check("t3_dv", 32'(data_valid), 32'd0);
    check("t3_busy_low", 32'(busy), 32'd0);
    step();
    check("t3_se_one_cycle", 32'(stop_error), 32'd0);
    repeat (4) step();

    // Test 4: false start, line low for 4 cycles.
    prescale = 6'd16;
    step();
    line_len = 16;
    for (int t = 0; t < 16; t++) line_buf[t] = (t >= 4);
    drive_line();
    repeat (LAT) step();
    check("t4_en_low", 32'(edge_cnt_en), 32'd0);
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_no_strobes", 32'({data_valid, parity_error, stop_error}), 32'd0);
    repeat (4) step();

    // Test 5: 0x55 with a single-sample glitch at mid of data bit 3,
    // then back-to-back 0x00 and 0xFF.
    dv_log.delete();
    send(8'h55, 1'b1, 1'b1, 4*16 + 8, -1);
    send(8'h00, 1'b1, 1'b1, -1, -1);
    send(8'hFF, 1'b1, 1'b1, -1, -1);
    repeat (LAT + 2) step();
    check("t5_strobe_count", 32'(dv_log.size()), 32'd3);
    if (dv_log.size() == 3) begin
      check("t5_byte0", 32'(dv_log[0]), 32'h55);
      check("t5_byte1", 32'(dv_log[1]), 32'h00);
      check("t5_byte2", 32'(dv_log[2]), 32'hFF);
    end
    repeat (3) step();

    // Test 6: reset during DATA, then a clean 0x5A.
    build_frame(8'hC3, 1'b1, 1'b1, -1, -1);
    model_add(cyc);
    for (int t = 0; t < 16*4; t++) begin
      rx_in = line_buf[t];
      step();
    end
    reset_n = 1'b0;
    rx_in   = 1'b1;
    clear_from(cyc);
    #1;
    check("t6_reset_now", 32'({edge_cnt_en, busy, data_valid, parity_error, stop_error, p_data}), 32'd0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();
    send(8'h5A, 1'b1, 1'b1, -1, -1);
    repeat (LAT) step();
    check("t6_dv", 32'(data_valid), 32'd1);
    check("t6_pdata", 32'(p_data), 32'h5A);
    repeat (4) step();

    // Unsupported prescale: line low must not start a frame.
    prescale = 6'd12;
    rx_in = 1'b0;
    repeat (20) step();
    check("bad_prescale_en", 32'(edge_cnt_en), 32'd0);
    check("bad_prescale_busy", 32'(busy), 32'd0);
    rx_in = 1'b1;
    repeat (LAT + 2) step();

    // Randomized frames: configs, bytes, parity/stop faults and glitches.
    for (int n = 0; n < 24; n++) begin
      if (n % 4 == 0) begin
        repeat (LAT + 2) step();
        case ($urandom_range(2, 0))
          0: prescale = 6'd8;
          1: prescale = 6'd16;
          default: prescale = 6'd32;
        endcase
        parity_en   = 1'($urandom_range(1, 0));
        parity_type = 1'($urandom_range(1, 0));
        step();
      end
      P      = int'(prescale);
      nb     = 10 + int'(parity_en);
      d      = 8'($urandom);
      par_ok = ($urandom_range(4, 0) != 0);
      stp    = ($urandom_range(5, 0) != 0);
      gsel   = $urandom_range(2, 0);
      g1 = -1; g2 = -1;
      if (gsel == 1) begin
        g1 = $urandom_range(nb*P - 1, P);
      end else if (gsel == 2) begin
        j  = $urandom_range(nb - 1, 1);
        g1 = j*P + P/2 - 1 + $urandom_range(1, 0);
        g2 = g1 + 1;
      end
      send(d, par_ok, stp, g1, g2);
      gap = $urandom_range(3, 0);
      repeat (gap) step();
    end
    repeat (LAT + 10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
